// File: rtl/vip_axis_c2h_tx.sv
// Card-to-host transmit path: captures wide VIP words into a small FIFO and
// serializes each one LSB-first into AXI-stream beats for the XDMA C2H port.
module vip_axis_c2h_tx #(
    parameter int C_DATA_WIDTH           = 64,
    parameter int XDMA_TRANSFER_SIZE_OUT = 100,
    parameter int FIFO_DEPTH             = 4,
    parameter int WORDS_PER_PKT          = 1
) (
    input  logic                                axi_clk,
    input  logic                                axi_rst,
    input  logic                                vip_data_valid_i,
    input  logic [XDMA_TRANSFER_SIZE_OUT-1:0]   vip_data_out_i,
    output logic                                vip_ready_o,
    output logic [C_DATA_WIDTH-1:0]             m_axis_c2h_tdata_0,
    output logic [C_DATA_WIDTH/8-1:0]           m_axis_c2h_tkeep_0,
    output logic                                m_axis_c2h_tlast_0,
    output logic                                m_axis_c2h_tvalid_0,
    input  logic                                m_axis_c2h_tready_0,
    output logic                                overflow_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o
);

    localparam int BEATS      = (XDMA_TRANSFER_SIZE_OUT + C_DATA_WIDTH - 1) / C_DATA_WIDTH;
    localparam int LAST_BITS  = XDMA_TRANSFER_SIZE_OUT - (BEATS - 1) * C_DATA_WIDTH;
    localparam int KEEP_W     = C_DATA_WIDTH / 8;
    localparam int LAST_BYTES = (LAST_BITS + 7) / 8;
    localparam int PAD_W      = BEATS * C_DATA_WIDTH;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WIP_W      = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

    localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [XDMA_TRANSFER_SIZE_OUT-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;
    logic [0:0]        r_state;
    logic [PAD_W-1:0]  r_word;
    logic [BEAT_W-1:0] r_beat;
    logic [WIP_W-1:0]  r_wip;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic              w_hs;
    logic              w_last_beat;
    logic              w_last_word;
    logic              w_word_done;
    logic [C_DATA_WIDTH-1:0] w_beat_data [BEATS];

    // Readiness comes only from the registered level, so a pop never frees a slot
    // for a strobe in the same cycle and a full FIFO is never overwritten.
    assign w_ready     = (r_level != LVL_W'(FIFO_DEPTH));
    assign w_push      = vip_data_valid_i && w_ready;
    assign w_valid     = (r_state == S_SEND);
    assign w_hs        = w_valid && m_axis_c2h_tready_0;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_word = (r_wip == WIP_W'(WORDS_PER_PKT - 1));
    assign w_word_done = w_hs && w_last_beat;
    assign w_pop       = (r_level != '0) && ((r_state == S_IDLE) || w_word_done);

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign w_beat_data[gi] = r_word[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
    endgenerate

    assign vip_ready_o         = w_ready;
    assign overflow_o          = r_overflow;
    assign fifo_level_o        = r_level;
    assign m_axis_c2h_tvalid_0 = w_valid;
    assign m_axis_c2h_tdata_0  = w_beat_data[r_beat];
    assign m_axis_c2h_tkeep_0  = !w_valid ? '0 : (w_last_beat ? LAST_KEEP : '1);
    assign m_axis_c2h_tlast_0  = w_valid && w_last_beat && w_last_word;

    always_ff @(posedge axi_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= vip_data_out_i;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_beat     <= '0;
            r_wip      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (vip_data_valid_i && !w_ready) begin
                r_overflow <= 1'b1;
            end
            // A word finishing with another queued reloads at the same edge, no bubble.
            if (w_pop) begin
                r_word  <= PAD_W'(r_mem[r_rd_ptr]);
                r_beat  <= '0;
                r_state <= S_SEND;
            end else if (w_word_done) begin
                r_state <= S_IDLE;
            end else if (w_hs) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (w_word_done) begin
                r_wip <= w_last_word ? '0 : r_wip + WIP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vip_axis_c2h_tx.sv
// Bench for vip_axis_c2h_tx: one instance with defaults, one with three words per
// packet; expected beats are queued on each strobe and matched at every handshake.
module tb_vip_axis_c2h_tx;

    logic         clk;
    logic         rst;
    logic         tready;

    logic         a_valid;
    logic [99:0]  a_data;
    logic         a_ready;
    logic [63:0]  a_tdata;
    logic [7:0]   a_tkeep;
    logic         a_tlast;
    logic         a_tvalid;
    logic         a_ovf;
    logic [2:0]   a_level;

    logic         b_valid;
    logic [99:0]  b_data;
    logic         b_ready;
    logic [63:0]  b_tdata;
    logic [7:0]   b_tkeep;
    logic         b_tlast;
    logic         b_tvalid;
    logic         b_ovf;
    logic [2:0]   b_level;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats_a = 0;
    int n_beats_b = 0;
    int wc_b = 0;
    logic watch_gap = 1'b0;
    logic seen_valid = 1'b0;
    int gap_errs = 0;

    logic [72:0] q_a[$];
    logic [72:0] q_b[$];

    vip_axis_c2h_tx u_dut_a (
        .axi_clk             (clk),
        .axi_rst             (rst),
        .vip_data_valid_i    (a_valid),
        .vip_data_out_i      (a_data),
        .vip_ready_o         (a_ready),
        .m_axis_c2h_tdata_0  (a_tdata),
        .m_axis_c2h_tkeep_0  (a_tkeep),
        .m_axis_c2h_tlast_0  (a_tlast),
        .m_axis_c2h_tvalid_0 (a_tvalid),
        .m_axis_c2h_tready_0 (tready),
        .overflow_o          (a_ovf),
        .fifo_level_o        (a_level)
    );

    vip_axis_c2h_tx #(.WORDS_PER_PKT(3)) u_dut_b (
        .axi_clk             (clk),
        .axi_rst             (rst),
        .vip_data_valid_i    (b_valid),
        .vip_data_out_i      (b_data),
        .vip_ready_o         (b_ready),
        .m_axis_c2h_tdata_0  (b_tdata),
        .m_axis_c2h_tkeep_0  (b_tkeep),
        .m_axis_c2h_tlast_0  (b_tlast),
        .m_axis_c2h_tvalid_0 (b_tvalid),
        .m_axis_c2h_tready_0 (tready),
        .overflow_o          (b_ovf),
        .fifo_level_o        (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the two expected beats of a 100-bit word (64 + 36 bits, keep 8'h1F on the tail).
    task automatic expect_word_a(input logic [99:0] w);
        q_a.push_back({w[63:0], 8'hFF, 1'b0});
        q_a.push_back({28'h0, w[99:64], 8'h1F, 1'b1});
    endtask

    task automatic expect_word_b(input logic [99:0] w);
        q_b.push_back({w[63:0], 8'hFF, 1'b0});
        q_b.push_back({28'h0, w[99:64], 8'h1F, (wc_b == 2)});
        wc_b = (wc_b + 1) % 3;
    endtask

    // One clock of strobes on either instance; inputs change 1 time unit after the edge.
    task automatic drive_cycle(input logic en_a, input logic [99:0] da, input logic acc_a,
                               input logic en_b, input logic [99:0] db);
        a_valid = en_a;
        a_data  = da;
        b_valid = en_b;
        b_data  = db;
        if (en_a && acc_a) expect_word_a(da);
        if (en_b) expect_word_b(db);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (q_a.size() == 0) && (q_b.size() == 0) && !a_tvalid && !b_tvalid;
        end
        check_eq(tag, done, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (watch_gap) begin
                if (a_tvalid) seen_valid = 1'b1;
                if (seen_valid && n_beats_a < 40 && !a_tvalid) gap_errs++;
            end
            if (a_tvalid && tready) begin
                check_eq("a_beat_expected", (q_a.size() != 0), 1'b1);
                if (q_a.size() != 0) begin
                    check_eq("a_beat", {a_tdata, a_tkeep, a_tlast}, q_a.pop_front());
                end
                n_beats_a++;
                $display("beat A data=%h keep=%h last=%b", a_tdata, a_tkeep, a_tlast);
            end
            if (b_tvalid && tready) begin
                check_eq("b_beat_expected", (q_b.size() != 0), 1'b1);
                if (q_b.size() != 0) begin
                    check_eq("b_beat", {b_tdata, b_tkeep, b_tlast}, q_b.pop_front());
                end
                n_beats_b++;
                $display("beat B data=%h keep=%h last=%b", b_tdata, b_tkeep, b_tlast);
            end
        end
    end

    initial begin
        logic [99:0] w1;
        logic [99:0] w2;
        logic        got;

        rst     = 1'b1;
        tready  = 1'b1;
        a_valid = 1'b0;
        a_data  = '0;
        b_valid = 1'b0;
        b_data  = '0;
        w1 = 100'hA_5555_6666_1234_5678_9ABC_DEF0;
        w2 = 100'h3_CAFE_BABE_0011_2233_4455_6677;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", a_tvalid, 1'b0);
        check_eq("rst_tlast", a_tlast, 1'b0);
        check_eq("rst_tkeep", a_tkeep, 8'h00);
        check_eq("rst_tdata", a_tdata, 64'h0);
        check_eq("rst_level", a_level, 3'd0);
        check_eq("rst_ready", a_ready, 1'b1);
        check_eq("rst_ovf", a_ovf, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, free-flowing sink; tvalid one edge after capture.
        drive_cycle(1'b1, w1, 1'b1, 1'b0, '0);
        check_eq("t1_tvalid_at_capture", a_tvalid, 1'b0);
        check_eq("t1_level_at_capture", a_level, 3'd1);
        @(posedge clk);
        #1;
        check_eq("t1_tvalid_after_load", a_tvalid, 1'b1);
        drain("t1_drain");
        $display("test1 done");

        // Backpressure on beat0 for five cycles.
        tready = 1'b0;
        drive_cycle(1'b1, w2, 1'b1, 1'b0, '0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = a_tvalid;
        end
        check_eq("t2_tvalid_seen", got, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("t2_hold_valid", a_tvalid, 1'b1);
            check_eq("t2_hold_beat", {a_tdata, a_tkeep, a_tlast}, {w2[63:0], 8'hFF, 1'b0});
        end
        tready = 1'b1;
        drain("t2_drain");
        $display("test2 done");

        // Overflow: six back-to-back strobes into a stalled sink.
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive_cycle(1'b1, 100'(i), 1'b1, 1'b0, '0);
        end
        check_eq("t3_level_full", a_level, 3'd4);
        check_eq("t3_ready_full", a_ready, 1'b0);
        check_eq("t3_ovf_before", a_ovf, 1'b0);
        drive_cycle(1'b1, 100'd6, 1'b0, 1'b0, '0);
        check_eq("t3_ovf_set", a_ovf, 1'b1);
        check_eq("t3_level_held", a_level, 3'd4);
        n_beats_a = 0;
        tready = 1'b1;
        drain("t3_drain");
        check_eq("t3_beats", n_beats_a, 10);
        check_eq("t3_ovf_sticky", a_ovf, 1'b1);
        $display("test3 done");

        // Three words per packet on instance B.
        n_beats_b = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b1, {4'(i), 32'hF0F0_0000 + 32'(i), 64'h1111_2222_3333_0000 + 64'(i)});
        end
        drain("t4_drain");
        check_eq("t4_beats", n_beats_b, 12);
        $display("test4 done");

        // Reset mid-word: A after its beat0 handshake, B in the second word of a packet.
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 100'h1_0000_0001_0000_0000_0000_0011);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 100'h2_0000_0002_0000_0000_0000_0022);
        drive_cycle(1'b1, w1, 1'b1, 1'b0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
        wc_b = 0;
        @(posedge clk);
        #1;
        check_eq("t5_tvalid", a_tvalid, 1'b0);
        check_eq("t5_level", a_level, 3'd0);
        check_eq("t5_ovf", a_ovf, 1'b0);
        check_eq("t5_tlast", a_tlast, 1'b0);
        check_eq("t5_b_tvalid", b_tvalid, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_beats_b = 0;
        drive_cycle(1'b1, w2, 1'b1, 1'b1, 100'h5_0000_0005_0000_0000_0000_0055);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 100'h6_0000_0006_0000_0000_0000_0066);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 100'h7_0000_0007_0000_0000_0000_0077);
        drain("t5_drain");
        check_eq("t5_b_beats", n_beats_b, 6);
        $display("test5 done");

        // Throughput: strobe every other cycle keeps tvalid continuously high.
        n_beats_a  = 0;
        gap_errs   = 0;
        seen_valid = 1'b0;
        watch_gap  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, {4'(i), 32'hABCD_0000 + 32'(i), 64'h9000_0000_0000_0000 + 64'(i)}, 1'b1, 1'b0, '0);
            @(posedge clk);
            #1;
        end
        drain("t6_drain");
        watch_gap = 1'b0;
        check_eq("t6_beats", n_beats_a, 40);
        check_eq("t6_gaps", gap_errs, 0);
        $display("test6 done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
